traceback_unit: RTL

//  Reader side of the Smith-Waterman pointer matrix.
//  - The PE array writes one `direction` pointer per (row, col) cell into pointer RAM.
//  - This block starts at the max-score cell reported by the array and walks the pointers

---
 rtl/traceback_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/traceback_unit.sv
// Smith-Waterman traceback walker: reads pointer RAM from the max-score cell back to Nil/edge, one op per step.
// Direction encoding: 0 Nil, 1 Diagonal, 2 Left, 3 Above. Define TRACEBACK_STATS_EN to add diag_cnt/gap_cnt.
module traceback_unit #(
  parameter int len1    = 5,
  parameter int len2    = 5,
  parameter int MAXOPS  = len1 + len2,
  parameter int SCORE_W = 16,
  localparam int ROW_W  = $clog2(len1) + 1,
  localparam int COL_W  = $clog2(len2) + 1,
  localparam int STEP_W = $clog2(MAXOPS + 1),
  localparam int CNT_W  = $clog2(len1 + len2) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_W-1:0]          start_row,
  input  logic [COL_W-1:0]          start_col,
  input  logic signed [SCORE_W-1:0] start_score,
  output logic                      rd_en,
  output logic [ROW_W-1:0]          rd_row,
  output logic [COL_W-1:0]          rd_col,
  input  logic [1:0]                rd_data,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [1:0]                op_dir,
  output logic [ROW_W-1:0]          op_row,
  output logic [COL_W-1:0]          op_col,
  output logic                      op_last,
  output logic                      busy,
  output logic                      done
`ifdef TRACEBACK_STATS_EN
  ,
  output logic [CNT_W-1:0]          diag_cnt,
  output logic [CNT_W-1:0]          gap_cnt
`endif
);

  typedef enum logic [1:0] {
    DIR_NIL   = 2'd0,
    DIR_DIAG  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_ABOVE = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_FINISH
  } state_e;

  localparam logic signed [SCORE_W-1:0] ZERO_SCORE = '0;
  localparam logic [STEP_W-1:0]         LAST_STEP  = STEP_W'(MAXOPS - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  dir_e               r_dir;
  logic [STEP_W-1:0]  r_step;

  logic [ROW_W-1:0]   w_next_row;
  logic [COL_W-1:0]   w_next_col;
  logic               w_last;
  logic               w_start_go;
  logic               w_start_skip;
  logic               w_handshake;

  // A walk needs a positive score and a cell off both boundaries; anything else finishes empty.
  assign w_start_go   = start && (start_score > ZERO_SCORE) &&
                        (start_row != '0) && (start_col != '0);
  assign w_start_skip = start && !w_start_go;
  assign w_handshake  = (r_state == S_EMIT) && op_ready;

  always_comb begin
    w_next_row = r_row;
    w_next_col = r_col;
    case (r_dir)
      DIR_DIAG: begin
        w_next_row = r_row - ROW_W'(1);
        w_next_col = r_col - COL_W'(1);
      end
      DIR_ABOVE: w_next_row = r_row - ROW_W'(1);
      DIR_LEFT:  w_next_col = r_col - COL_W'(1);
      default: ;
    endcase
  end

  // EMIT is only entered with a non-Nil pointer on a cell with r,c >= 1, so the decrements cannot wrap.
  assign w_last = (w_next_row == '0) || (w_next_col == '0) || (r_step == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_go)        w_next_state = S_READ;
        else if (w_start_skip) w_next_state = S_FINISH;
      end
      S_READ: w_next_state = S_WAIT;
      S_WAIT: begin
        if (dir_e'(rd_data) == DIR_NIL) w_next_state = S_FINISH;
        else                            w_next_state = S_EMIT;
      end
      S_EMIT: begin
        if (w_handshake) w_next_state = w_last ? S_FINISH : S_READ;
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_dir  <= DIR_NIL;
      r_step <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_go) begin
            r_row  <= start_row;
            r_col  <= start_col;
            r_step <= '0;
          end
        end
        S_WAIT: r_dir <= dir_e'(rd_data);
        S_EMIT: begin
          if (w_handshake && !w_last) begin
            r_row  <= w_next_row;
            r_col  <= w_next_col;
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en    = (r_state == S_READ);
  assign rd_row   = r_row;
  assign rd_col   = r_col;
  assign op_valid = (r_state == S_EMIT);
  assign op_dir   = r_dir;
  assign op_row   = r_row;
  assign op_col   = r_col;
  assign op_last  = (r_state == S_EMIT) && w_last;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FINISH);

`ifdef TRACEBACK_STATS_EN
  logic [CNT_W-1:0] r_diag_cnt;
  logic [CNT_W-1:0] r_gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diag_cnt <= '0;
      r_gap_cnt  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_diag_cnt <= '0;
      r_gap_cnt  <= '0;
    end else if (w_handshake) begin
      if (r_dir == DIR_DIAG) r_diag_cnt <= r_diag_cnt + CNT_W'(1);
      else                   r_gap_cnt  <= r_gap_cnt + CNT_W'(1);
    end
  end

  assign diag_cnt = r_diag_cnt;
  assign gap_cnt  = r_gap_cnt;
`endif

  a_op_hold: assert property (@(posedge clk) disable iff (rst)
    (op_valid && !op_ready) |=> (op_valid && $stable(op_dir) && $stable(op_row) &&
                                 $stable(op_col) && $stable(op_last)));

  a_no_read_in_emit: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && op_valid));

endmodule
